dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 108 ++++++++++
 tb/tb_dmem_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data memory with a valid/ready request/response handshake.
// Each request waits a fixed number of cycles, then holds its response until the core takes it.
module dmem_responder #(
  parameter int AW   = 8,
  parameter int WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        op_we;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [3:0]  op_be;
  logic        accept;
  logic        commit;
  logic        in_range;
  logic [AW-1:0] idx;

  logic [31:0] mem [0:(1<<AW)-1];

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_valid && req_ready;
  assign commit    = (state == S_WAIT) && (cnt == 4'd0);
  assign in_range  = ((op_addr >> AW) == 32'd0);
  assign idx       = op_addr[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Counter starts at WAIT so rsp_valid rises WAIT+1 cycles after the accept edge.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = S_WAIT;
          cnt_next   = 4'(WAIT);
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_next = S_RESP;
        else             cnt_next   = cnt - 4'd1;
      end
      S_RESP: begin
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_we    <= 1'b0;
      op_addr  <= 32'd0;
      op_wdata <= 32'd0;
      op_be    <= 4'd0;
    end else if (accept) begin
      op_we    <= req_we;
      op_addr  <= req_addr;
      op_wdata <= req_wdata;
      op_be    <= req_be;
    end
  end

  // Storage is never reset; a reset during WAIT drops state to IDLE so commit never fires.
  always_ff @(posedge clk) begin
    if (commit && op_we && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (op_be[b]) mem[idx][8*b +: 8] <= op_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_err   <= !in_range;
      rsp_rdata <= (!op_we && in_range) ? mem[idx] : 32'd0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT=2 instance for most scenarios and a WAIT=0
// instance for the streaming throughput case.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid0 = 1'b0, req_ready0, req_we0 = 1'b0;
  logic [31:0] req_addr0 = '0, req_wdata0 = '0;
  logic [3:0]  req_be0 = '0;
  logic        rsp_valid0, rsp_ready0 = 1'b0, rsp_err0;
  logic [31:0] rsp_rdata0;

  int assertions = 0;
  int failures   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.AW(8), .WAIT(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.AW(8), .WAIT(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  // Runs one full transaction on the WAIT=2 instance; lat = edges from accept to rsp_valid.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output int lat, output logic [31:0] rdata,
                        output logic err);
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    $display("txn we=%0b addr=%h wdata=%h be=%h -> lat=%0d rdata=%h err=%0b",
             we, addr, wdata, be, lat, rdata, err);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    assertions++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    assertions++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    assertions++; if (rsp_rdata !== 32'd0) begin failures++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    assertions++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic er;
    // issued in the cycle right after reset release: must be accepted on the first edge
    do_req(1'b1, 32'h05, 32'hDEADBEEF, 4'hF, lat, rd, er);
    assertions++; if (lat !== 3) begin failures++; $display("FAIL store_latency got %0d want 3", lat); end
    assertions++; if (rd !== 32'd0) begin failures++; $display("FAIL store_rdata got %h want 0", rd); end
    assertions++; if (er !== 1'b0) begin failures++; $display("FAIL store_err got %b want 0", er); end
    do_req(1'b0, 32'h05, 32'h0, 4'h0, lat, rd, er);
    assertions++; if (lat !== 3) begin failures++; $display("FAIL load_latency got %0d want 3", lat); end
    assertions++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL load_rdata got %h want DEADBEEF", rd); end
    assertions++; if (er !== 1'b0) begin failures++; $display("FAIL load_err got %b want 0", er); end
  endtask

  task automatic test_byte_enable();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 32'h05, 32'h0000AA00, 4'h2, lat, rd, er);
    do_req(1'b0, 32'h05, 32'h0, 4'hF, lat, rd, er);
    assertions++; if (rd !== 32'hDEADAAEF) begin failures++; $display("FAIL be_0x2 got %h want DEADAAEF", rd); end
    do_req(1'b1, 32'h05, 32'h12345678, 4'h9, lat, rd, er);
    do_req(1'b0, 32'h05, 32'h0, 4'h0, lat, rd, er);
    assertions++; if (rd !== 32'h12ADAA78) begin failures++; $display("FAIL be_0x9 got %h want 12ADAA78", rd); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 32'h00, 32'hCAFEF00D, 4'hF, lat, rd, er);
    // 0x100 aliases word 0 in the low bits; it must not write
    do_req(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, lat, rd, er);
    assertions++; if (er !== 1'b1) begin failures++; $display("FAIL oor_store_err got %b want 1", er); end
    do_req(1'b0, 32'h100, 32'h0, 4'h0, lat, rd, er);
    assertions++; if (er !== 1'b1) begin failures++; $display("FAIL oor_load_err got %b want 1", er); end
    assertions++; if (rd !== 32'd0) begin failures++; $display("FAIL oor_load_rdata got %h want 0", rd); end
    do_req(1'b0, 32'h80000000, 32'h0, 4'h0, lat, rd, er);
    assertions++; if (er !== 1'b1) begin failures++; $display("FAIL oor_msb_err got %b want 1", er); end
    do_req(1'b0, 32'h00, 32'h0, 4'h0, lat, rd, er);
    assertions++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL word0_after_oor got %h want CAFEF00D", rd); end
    assertions++; if (er !== 1'b0) begin failures++; $display("FAIL word0_err got %b want 0", er); end
  endtask

  task automatic test_backpressure();
    int lat, w; logic [31:0] rd; logic er;
    req_we = 1'b0; req_addr = 32'h05; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    w = 0;
    while (rsp_valid !== 1'b1 && w < 40) begin @(posedge clk); #1; w++; end
    assertions++; if (w !== 3) begin failures++; $display("FAIL bp_latency got %0d want 3", w); end
    // a store request presented during RESP must be ignored
    req_we = 1'b1; req_addr = 32'h05; req_wdata = 32'h0; req_be = 4'hF; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      assertions++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got %b want 1", k, rsp_valid); end
      assertions++; if (rsp_rdata !== 32'h12ADAA78) begin failures++; $display("FAIL bp_rdata[%0d] got %h want 12ADAA78", k, rsp_rdata); end
      assertions++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL bp_err[%0d] got %b want 0", k, rsp_err); end
      assertions++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_req_ready[%0d] got %b want 0", k, req_ready); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    assertions++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_exit_valid got %b want 0", rsp_valid); end
    assertions++; if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_exit_no_accept got req_ready=%b want 1", req_ready); end
    req_valid = 1'b0;
    $display("txn backpressure load addr=05 held 5 cycles");
    do_req(1'b0, 32'h05, 32'h0, 4'h0, lat, rd, er);
    assertions++; if (rd !== 32'h12ADAA78) begin failures++; $display("FAIL bp_ignored_store got %h want 12ADAA78", rd); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 32'h07, 32'h11111111, 4'hF, lat, rd, er);
    do_req(1'b0, 32'h05, 32'h0, 4'h0, lat, rd, er);
    req_we = 1'b1; req_addr = 32'h07; req_wdata = 32'h22222222; req_be = 4'hF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    assertions++; if (req_ready !== 1'b0) begin failures++; $display("FAIL abort_accepted got req_ready=%b want 0", req_ready); end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    assertions++; if (req_ready !== 1'b1) begin failures++; $display("FAIL abort_req_ready got %b want 1", req_ready); end
    assertions++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL abort_rsp_valid got %b want 0", rsp_valid); end
    assertions++; if (rsp_rdata !== 32'd0) begin failures++; $display("FAIL abort_rsp_rdata got %h want 0", rsp_rdata); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    $display("txn reset pulse during store addr=07");
    do_req(1'b0, 32'h07, 32'h0, 4'h0, lat, rd, er);
    assertions++; if (rd !== 32'h11111111) begin failures++; $display("FAIL abort_store_leak got %h want 11111111", rd); end
    do_req(1'b0, 32'h05, 32'h0, 4'h0, lat, rd, er);
    assertions++; if (rd !== 32'h12ADAA78) begin failures++; $display("FAIL storage_kept got %h want 12ADAA78", rd); end
  endtask

  task automatic test_back_to_back_wait0();
    logic [8:0] acc, vld;
    req_we0 = 1'b0; req_addr0 = 32'h200; req_valid0 = 1'b1; rsp_ready0 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      acc[i] = req_ready0;
      @(posedge clk); #1;
      vld[i] = rsp_valid0;
      if (rsp_valid0 === 1'b1) begin
        assertions++; if (rsp_err0 !== 1'b1 || rsp_rdata0 !== 32'd0) begin failures++; $display("FAIL w0_rsp[%0d] got err=%b rdata=%h want err=1 rdata=0", i, rsp_err0, rsp_rdata0); end
      end
      $display("txn wait0 cycle %0d accept=%0b rsp_valid=%0b", i, acc[i], vld[i]);
    end
    req_valid0 = 1'b0; rsp_ready0 = 1'b0;
    assertions++; if (acc !== 9'b001001001) begin failures++; $display("FAIL w0_accept_pattern got %b want 001001001", acc); end
    assertions++; if (vld !== 9'b010010010) begin failures++; $display("FAIL w0_valid_pattern got %b want 010010010", vld); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enable();
    test_out_of_range();
    test_backpressure();
    test_reset_abort();
    test_back_to_back_wait0();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
